// File: rtl/poly_stream_bridge_if.sv
// rtl/poly_stream_bridge_if.sv - bundle of bridge-side handshake and memory-port signals
//
// Ports grouped here:
//   cmd_*   : command request (valid/ready) and fields from the register block
//   sts_*   : busy, done pulse, sticky TLAST error, beat count
//   s_t*    : inbound 64-bit stream (host DMA -> bridge)
//   m_t*    : outbound 64-bit stream (bridge -> host DMA)
//   mem_*   : polynomial-processor memory port
// Modports:
//   master  : the bridge's view (drives cmd_ready, sts_*, s_tready, m_t*, mem_* outputs)
//   slave   : the surrounding system's view
interface poly_stream_bridge_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int COEFF_WIDTH = 60,
  parameter int ADDR_WIDTH  = 11,
  parameter int PSEL_WIDTH  = 3,
  parameter int MSEL_WIDTH  = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_dir;
  logic                    cmd_bcast;
  logic [PSEL_WIDTH-1:0]   cmd_proc;
  logic [MSEL_WIDTH-1:0]   cmd_mem;
  logic [ADDR_WIDTH-1:0]   cmd_base;
  logic [ADDR_WIDTH:0]     cmd_len;

  logic                    sts_busy;
  logic                    sts_done;
  logic                    sts_err;
  logic [ADDR_WIDTH:0]     sts_count;

  logic [DATA_WIDTH-1:0]   s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic                    s_tlast;

  logic [DATA_WIDTH-1:0]   m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic [DATA_WIDTH/8-1:0] m_tstrb;

  logic                    mem_own;
  logic [PSEL_WIDTH-1:0]   mem_proc_sel;
  logic [MSEL_WIDTH-1:0]   mem_top_sel;
  logic                    mem_all;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [COEFF_WIDTH-1:0]  mem_din;
  logic                    mem_we;
  logic                    mem_re;
  logic [COEFF_WIDTH-1:0]  mem_dout;

  modport master (
    input  cmd_valid, cmd_dir, cmd_bcast, cmd_proc, cmd_mem, cmd_base, cmd_len,
    output cmd_ready,
    output sts_busy, sts_done, sts_err, sts_count,
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output m_tdata, m_tvalid, m_tlast, m_tstrb,
    input  m_tready,
    output mem_own, mem_proc_sel, mem_top_sel, mem_all, mem_addr, mem_din, mem_we, mem_re,
    input  mem_dout
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_bcast, cmd_proc, cmd_mem, cmd_base, cmd_len,
    input  cmd_ready,
    input  sts_busy, sts_done, sts_err, sts_count,
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tstrb,
    output m_tready,
    input  mem_own, mem_proc_sel, mem_top_sel, mem_all, mem_addr, mem_din, mem_we, mem_re,
    output mem_dout
  );
endinterface

// File: rtl/poly_stream_bridge.sv
// rtl/poly_stream_bridge.sv - command-driven burst bridge between stream pair and processor memory
//
// Ports:
//   aclk   : clock
//   areset : asynchronous active-high reset
//   bus    : poly_stream_bridge_if.master (command, status, s/m streams, memory port)
// A write command moves cmd_len stream beats into processor memory (optionally broadcast);
// a read command issues cmd_len memory reads, lands them in an output FIFO and streams them out.
module poly_stream_bridge #(
  parameter int DATA_WIDTH  = 64,
  parameter int COEFF_WIDTH = 60,
  parameter int ADDR_WIDTH  = 11,
  parameter int PSEL_WIDTH  = 3,
  parameter int MSEL_WIDTH  = 4,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  poly_stream_bridge_if.master  bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_FIN} state_t;
  state_t state_q, state_d;

  // latched command
  logic                   dir_q;
  logic                   bcast_q;
  logic [PSEL_WIDTH-1:0]  proc_q;
  logic [MSEL_WIDTH-1:0]  msel_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [CNT_W-1:0]       len_q;

  // progress / status
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       issued_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  // registered memory port
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COEFF_WIDTH-1:0] din_q;
  logic                   we_q;
  logic                   re_q;

  // read return path
  logic [RD_LATENCY-1:0]  tag_q;
  logic [COEFF_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [OCC_W-1:0]       occ_q;
  logic [OCC_W-1:0]       inflight_q;

  logic                   cmd_ready_c;
  logic                   s_tready_c;
  logic                   rd_issue;
  logic                   accept;
  logic                   wr_beat;
  logic                   wr_last;
  logic                   push;
  logic                   pop;
  logic                   credit_ok;
  logic                   fifo_nonempty;
  logic [CNT_W-1:0]       last_idx;

  assign last_idx      = len_q - CNT_W'(1);
  assign fifo_nonempty = (occ_q != '0);
  // Reads already issued plus data waiting in the FIFO must never exceed the FIFO size,
  // so every landing read is guaranteed a slot regardless of output backpressure.
  assign credit_ok     = ({1'b0, inflight_q} + {1'b0, occ_q}) < (OCC_W + 1)'(FIFO_DEPTH);
  assign accept        = bus.cmd_valid & cmd_ready_c;
  assign wr_beat       = bus.s_tvalid & s_tready_c;
  assign wr_last       = (count_q == last_idx);
  assign push          = tag_q[RD_LATENCY-1];
  assign pop           = fifo_nonempty & bus.m_tready;

  // FSM: state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.cmd_len == '0)  state_d = S_FIN;
          else if (!bus.cmd_dir)  state_d = S_WR;
          else                    state_d = S_RD;
        end
      end
      S_WR:    if (wr_beat && (bus.s_tlast || wr_last)) state_d = S_FIN;
      S_RD:    if (issued_q == len_q) state_d = S_DRAIN;
      S_DRAIN: if (inflight_q == '0 && !fifo_nonempty) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready_c = 1'b0;
    s_tready_c  = 1'b0;
    rd_issue    = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready_c = 1'b1;
      S_WR:   s_tready_c  = 1'b1;
      S_RD:   rd_issue    = (issued_q < len_q) && credit_ok;
      default: ;
    endcase
  end

  // command latch, counters, registered memory port
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      dir_q    <= 1'b0;
      bcast_q  <= 1'b0;
      proc_q   <= '0;
      msel_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      count_q  <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      done_q <= 1'b0;
      if (accept) begin
        dir_q    <= bus.cmd_dir;
        bcast_q  <= bus.cmd_bcast;
        proc_q   <= bus.cmd_proc;
        msel_q   <= bus.cmd_mem;
        base_q   <= bus.cmd_base;
        len_q    <= bus.cmd_len;
        count_q  <= '0;
        issued_q <= '0;
        err_q    <= 1'b0;
        busy_q   <= 1'b1;
      end
      if (wr_beat) begin
        we_q    <= 1'b1;
        din_q   <= bus.s_tdata[COEFF_WIDTH-1:0];
        addr_q  <= base_q + count_q[ADDR_WIDTH-1:0];
        count_q <= count_q + CNT_W'(1);
        // TLAST must coincide exactly with the final beat; early or missing TLAST is an error
        if (bus.s_tlast != wr_last) err_q <= 1'b1;
      end
      if (rd_issue) begin
        re_q     <= 1'b1;
        addr_q   <= base_q + issued_q[ADDR_WIDTH-1:0];
        issued_q <= issued_q + CNT_W'(1);
      end
      if (pop) count_q <= count_q + CNT_W'(1);
      if (state_q == S_FIN) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  // read tags, in-flight tracking, FIFO pointers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tag_q      <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      // tag_q[k] is high RD_LATENCY-1-k cycles before the matching mem_dout is valid
      tag_q[0] <= re_q;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (rd_issue && !push)      inflight_q <= inflight_q + OCC_W'(1);
      else if (push && !rd_issue) inflight_q <= inflight_q - OCC_W'(1);
      if (push && !pop)           occ_q <= occ_q + OCC_W'(1);
      else if (pop && !push)      occ_q <= occ_q - OCC_W'(1);
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wptr_q] <= bus.mem_dout;
  end

  logic unused_tdata;
  assign unused_tdata = ^bus.s_tdata;

  assign bus.cmd_ready    = cmd_ready_c;
  assign bus.sts_busy     = busy_q;
  assign bus.sts_done     = done_q;
  assign bus.sts_err      = err_q;
  assign bus.sts_count    = count_q;
  assign bus.s_tready     = s_tready_c;
  assign bus.m_tvalid     = fifo_nonempty;
  // FIFO storage is not reset, so gate the head word to keep m_tdata at zero while empty
  assign bus.m_tdata      = fifo_nonempty ? DATA_WIDTH'(fifo_mem[rptr_q]) : '0;
  assign bus.m_tlast      = fifo_nonempty && (count_q == last_idx);
  assign bus.m_tstrb      = '1;
  assign bus.mem_own      = busy_q;
  assign bus.mem_proc_sel = busy_q ? proc_q : '0;
  assign bus.mem_top_sel  = busy_q ? msel_q : '0;
  assign bus.mem_all      = busy_q & bcast_q & ~dir_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_din      = din_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_re       = re_q;
endmodule

// File: tb/tb_poly_stream_bridge.sv
// tb/tb_poly_stream_bridge.sv - self-checking bench for poly_stream_bridge
module tb_poly_stream_bridge;
  localparam int DW = 64;
  localparam int CW = 60;
  localparam int AW = 11;
  localparam int PW = 3;
  localparam int MW = 4;
  localparam int RL = 2;
  localparam int FD = 4;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  poly_stream_bridge_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW),
                          .PSEL_WIDTH(PW), .MSEL_WIDTH(MW)) bus ();

  poly_stream_bridge #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW), .PSEL_WIDTH(PW),
                       .MSEL_WIDTH(MW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    logic        dir;
    logic        bcast;
    logic [2:0]  proc;
    logic [3:0]  msel;
    logic [10:0] base;
    logic [11:0] len;
    int          tlast_beat;
    bit          tog;
    logic        exp_err;
    logic [11:0] exp_count;
  } vec_t;

  vec_t vecs[8];
  int passed = 0;
  int total  = 0;

  logic [78:0] wr_q[$];
  logic [64:0] rd_q[$];
  logic [78:0] wexp;
  logic [64:0] rexp;
  logic [10:0] exp_rd_addr;
  logic [2:0]  cur_proc;
  logic [3:0]  cur_msel;
  int          outstanding = 0;
  int          we_total = 0;
  int          re_total = 0;

  function automatic logic [59:0] coeff(input logic [10:0] a);
    return {4'hA, a, ~a, 34'h2_3456_789A};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // memory model with two-cycle read latency; garbage when no read is landing
  logic [10:0] rp_a [2];
  logic        rp_v [2];
  initial begin
    rp_v[0] = 1'b0; rp_v[1] = 1'b0; rp_a[0] = '0; rp_a[1] = '0;
  end
  always @(posedge aclk) begin
    rp_a[0] <= bus.mem_addr;
    rp_v[0] <= bus.mem_re;
    rp_a[1] <= rp_a[0];
    rp_v[1] <= rp_v[0];
  end
  assign bus.mem_dout = rp_v[1] ? coeff(rp_a[1]) : 60'hBAD0BAD0BAD0BAD;

  // scoreboard monitor, sampling mid-cycle
  always @(negedge aclk) begin
    if (bus.mem_we) begin
      we_total++;
      if (wr_q.size() == 0) check("wr_unexpected", bus.mem_we, 1'b0);
      else begin
        wexp = wr_q.pop_front();
        check("wr_beat", {bus.mem_all, bus.mem_proc_sel, bus.mem_top_sel, bus.mem_addr, bus.mem_din}, wexp);
      end
    end
    if (bus.mem_re) begin
      re_total++;
      outstanding++;
      check("rd_issue", {bus.mem_all, bus.mem_proc_sel, bus.mem_top_sel, bus.mem_addr},
            {1'b0, cur_proc, cur_msel, exp_rd_addr});
      check("rd_credit", outstanding <= FD, 1'b1);
      exp_rd_addr = exp_rd_addr + 11'd1;
    end
    if (bus.m_tvalid && bus.m_tready) begin
      outstanding--;
      if (rd_q.size() == 0) check("rd_unexpected", bus.m_tvalid, 1'b0);
      else begin
        rexp = rd_q.pop_front();
        check("rd_beat", {bus.m_tlast, bus.m_tdata}, rexp);
      end
    end
  end

  task automatic run_cmd(input vec_t v, input string tag);
    int n;
    int cyc;
    bit done_seen;
    logic [63:0] d;
    @(posedge aclk); #1;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    check({tag, "_ready"}, bus.cmd_ready, 1'b1);
    bus.cmd_dir = v.dir; bus.cmd_bcast = v.bcast; bus.cmd_proc = v.proc;
    bus.cmd_mem = v.msel; bus.cmd_base = v.base; bus.cmd_len = v.len;
    bus.cmd_valid = 1'b1;
    cur_proc = v.proc; cur_msel = v.msel; exp_rd_addr = v.base;
    if (v.dir)
      for (int i = 0; i < int'(v.len); i++)
        rd_q.push_back({(i == int'(v.len) - 1), 4'h0, coeff(v.base + 11'(i))});
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge aclk);
    check({tag, "_accept"}, {bus.sts_busy, bus.mem_own, bus.sts_err, bus.cmd_ready, bus.sts_count},
          {4'b1100, 12'd0});
    @(posedge aclk); #1;
    bus.m_tready = 1'b1;
    if (!v.dir) begin
      n = (v.tlast_beat != 0 && v.tlast_beat < int'(v.len)) ? v.tlast_beat : int'(v.len);
      for (int i = 0; i < n; i++) begin
        d = {$urandom, $urandom};
        bus.s_tdata = d; bus.s_tvalid = 1'b1; bus.s_tlast = (i + 1 == v.tlast_beat);
        wr_q.push_back({v.bcast, v.proc, v.msel, v.base + 11'(i), d[59:0]});
        cyc = 0;
        @(negedge aclk);
        while (!bus.s_tready && cyc < 20) begin @(negedge aclk); cyc++; end
        if (!bus.s_tready) check({tag, "_tready_timeout"}, bus.s_tready, 1'b1);
        @(posedge aclk); #1;
      end
      bus.s_tdata = ~d; bus.s_tlast = 1'b0;
      @(negedge aclk);
      check({tag, "_surplus"}, bus.s_tready, 1'b0);
      bus.s_tvalid = 1'b0;
    end
    cyc = 0; done_seen = 0;
    while (!done_seen && cyc < 400) begin
      @(negedge aclk);
      if (bus.sts_done) done_seen = 1;
      else begin
        @(posedge aclk); #1;
        bus.m_tready = v.tog ? ~bus.m_tready : 1'b1;
        cyc++;
      end
    end
    check({tag, "_done_seen"}, done_seen, 1'b1);
    check({tag, "_status"}, {bus.sts_busy, bus.mem_own, bus.sts_err, bus.sts_count},
          {2'b00, v.exp_err, v.exp_count});
    @(negedge aclk);
    check({tag, "_pulse"}, bus.sts_done, 1'b0);
    check({tag, "_queues"}, {wr_q.size(), rd_q.size()}, 64'd0);
    @(posedge aclk); #1;
    bus.m_tready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {bus.cmd_ready, bus.sts_busy, bus.sts_done, bus.sts_err, bus.sts_count,
                          bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.mem_own, bus.mem_proc_sel,
                          bus.mem_top_sel, bus.mem_all, bus.mem_addr, bus.mem_we, bus.mem_re},
          {1'b1, 40'd0});
    check({tag, "_data"}, {bus.m_tdata, bus.mem_din}, 124'd0);
  endtask

  initial begin
    int cyc;
    int we0;
    int re0;
    bus.cmd_valid = 0; bus.cmd_dir = 0; bus.cmd_bcast = 0; bus.cmd_proc = 0; bus.cmd_mem = 0;
    bus.cmd_base = 0; bus.cmd_len = 0; bus.s_tdata = 0; bus.s_tvalid = 0; bus.s_tlast = 0;
    bus.m_tready = 0;
    exp_rd_addr = 0; cur_proc = 0; cur_msel = 0;

    @(posedge aclk); #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("tstrb", bus.m_tstrb, 8'hFF);
    check("idle_ready", {bus.cmd_ready, bus.sts_busy}, 2'b10);

    //            dir bc  proc msel base     len tlast tog err cnt
    vecs[0] = '{1'b0, 1'b0, 3'd5, 4'd3,  11'h7FE, 12'd4, 4, 1'b0, 1'b0, 12'd4};
    vecs[1] = '{1'b0, 1'b1, 3'd1, 4'd2,  11'h010, 12'd2, 2, 1'b0, 1'b0, 12'd2};
    vecs[2] = '{1'b1, 1'b1, 3'd6, 4'd1,  11'h010, 12'd2, 0, 1'b0, 1'b0, 12'd2};
    vecs[3] = '{1'b1, 1'b0, 3'd2, 4'd4,  11'h7FC, 12'd8, 0, 1'b1, 1'b0, 12'd8};
    vecs[4] = '{1'b0, 1'b0, 3'd3, 4'd5,  11'h200, 12'd4, 2, 1'b0, 1'b1, 12'd2};
    vecs[5] = '{1'b0, 1'b0, 3'd7, 4'd15, 11'h300, 12'd3, 0, 1'b0, 1'b1, 12'd3};
    vecs[6] = '{1'b1, 1'b0, 3'd0, 4'd0,  11'h000, 12'd1, 0, 1'b1, 1'b0, 12'd1};
    vecs[7] = '{1'b0, 1'b0, 3'd4, 4'd9,  11'h050, 12'd5, 5, 1'b0, 1'b0, 12'd5};

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("v%0d", i));

    // zero-length command: done two cycles after accept, no memory traffic
    we0 = we_total; re0 = re_total;
    bus.cmd_dir = 1'b0; bus.cmd_len = 12'd0; bus.cmd_base = 11'h123; bus.cmd_valid = 1'b1;
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge aclk);
    check("len0_cycle1", {bus.sts_done, bus.sts_busy}, 2'b01);
    @(negedge aclk);
    check("len0_cycle2", {bus.sts_done, bus.sts_busy, bus.sts_count}, {2'b10, 12'd0});
    check("len0_nomem", {we_total - we0, re_total - re0}, 64'd0);

    // reset in the middle of a read with data parked in the FIFO
    @(posedge aclk); #1;
    bus.m_tready = 1'b0;
    bus.cmd_dir = 1'b1; bus.cmd_bcast = 1'b0; bus.cmd_proc = 3'd2; bus.cmd_mem = 4'd1;
    bus.cmd_base = 11'h100; bus.cmd_len = 12'd8; bus.cmd_valid = 1'b1;
    cur_proc = 3'd2; cur_msel = 4'd1; exp_rd_addr = 11'h100;
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    @(negedge aclk);
    while (!bus.m_tvalid && cyc < 20) begin @(negedge aclk); cyc++; end
    check("rst_fifo_nonempty", bus.m_tvalid, 1'b1);
    @(posedge aclk); #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge aclk);
    areset = 1'b0;
    outstanding = 0;
    rd_q.delete();

    run_cmd(vecs[3], "post_rst_rd");
    run_cmd(vecs[0], "post_rst_wr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/poly_stream_bridge.md
Name: poly_stream_bridge

Overview:
- Parametrised, command-driven bridge between a 64-bit AXI-Stream pair and the polynomial-processor memory port.
- Each command moves a burst of cmd_len coefficients:
  - write direction: stream to processor memory, to one processor or broadcast to all;
  - read direction: processor memory to stream.
- The read path has a fixed memory read latency and tolerates output backpressure through an internal credit-controlled FIFO.
- Sits between the host DMA streams and the processor array; commands and status are driven from the register block.

Parameters:
- DATA_WIDTH, 64: stream word width.
- COEFF_WIDTH, 60: coefficient width, ≤ DATA_WIDTH.
- ADDR_WIDTH, 11: processor memory address width.
- PSEL_WIDTH, 3: processor select width.
- MSEL_WIDTH, 4: top memory select width.
- RD_LATENCY, 2: cycles from mem_re to valid mem_dout, ≥ 1.
- FIFO_DEPTH, 4: output FIFO entries, ≥ RD_LATENCY+2, power of two.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE
- cmd_dir  in  1  0 = stream→memory, 1 = memory→stream
- cmd_bcast  in  1  write to all processors (ignored when cmd_dir = 1)
- cmd_proc  in  PSEL_WIDTH  processor select
- cmd_mem  in  MSEL_WIDTH  top memory select
- cmd_base  in  ADDR_WIDTH  start address
- cmd_len  in  ADDR_WIDTH+1  coefficient count, 0..2^ADDR_WIDTH
- sts_busy  out  1  command in progress
- sts_done  out  1  one-cycle completion pulse
- sts_err  out  1  sticky TLAST error
- sts_count  out  ADDR_WIDTH+1  beats transferred in current/last command
- s_tdata  in  DATA_WIDTH
- s_tvalid  in  1
- s_tready  out  1
- s_tlast  in  1
- m_tdata  out  DATA_WIDTH  coefficient zero-extended
- m_tvalid  out  1
- m_tready  in  1
- m_tlast  out  1
- m_tstrb  out  DATA_WIDTH/8  constant all ones
- mem_own  out  1  bridge owns processor memory (interrupt line)
- mem_proc_sel  out  PSEL_WIDTH
- mem_top_sel  out  MSEL_WIDTH
- mem_all  out  1  broadcast enable
- mem_addr  out  ADDR_WIDTH
- mem_din  out  COEFF_WIDTH
- mem_we  out  1
- mem_re  out  1
- mem_dout  in  COEFF_WIDTH

Behaviour:
- Reset state (async assert, sync release): FSM = IDLE, cmd_ready = 1; all other outputs 0; FIFO empty; sts_err and sts_count cleared. Reset mid-burst abandons the transfer immediately with no done pulse.
- States: IDLE, WR, RD, DRAIN, FIN.
- IDLE:
  - On cmd_valid & cmd_ready, latch all cmd fields, clear sts_count and sts_err, set mem_own and sts_busy.
  - cmd_len = 0 → FIN; cmd_dir = 0 → WR; otherwise → RD.
- mem_proc_sel, mem_top_sel, mem_all are driven from latched fields while busy. mem_all = bcast & ~dir.
- WR:
  - s_tready = 1.
  - Each handshake registers mem_we = 1, mem_din = s_tdata[COEFF_WIDTH-1:0], mem_addr = base+count (mod 2^ADDR_WIDTH); latency 1 cycle. Then count increments.
  - s_tlast on a beat before the final one: set sts_err, write that beat, → FIN.
  - Final beat without s_tlast: set sts_err, → FIN.
  - After the final beat s_tready drops; surplus beats are not consumed.
- RD:
  - Issue mem_re with mem_addr = base+issued when issued < len and (in-flight + FIFO occupancy) < FIFO_DEPTH.
  - A RD_LATENCY shift register of re tags captures mem_dout into the FIFO.
  - When all reads are issued → DRAIN.
- DRAIN: wait until all in-flight reads have landed and the FIFO is empty, then → FIN.
- Output side: m_tvalid = FIFO not empty. count increments on m_tvalid & m_tready. m_tlast = 1 on beat count == len-1. m_tdata is held stable while m_tvalid & ~m_tready.
- FIN: sts_done = 1 for one cycle; mem_own and sts_busy drop; → IDLE.
- cmd_valid while busy is ignored (cmd_ready = 0).
- Address wrap: base + index is modulo 2^ADDR_WIDTH. cmd_len = 2^ADDR_WIDTH covers the full memory.

Test Plan:
- Write len=4, base=0x7FE, proc=5, TLAST on beat 4 → mem_we at addr 0x7FE, 0x7FF, 0x000, 0x001; mem_proc_sel=5; done pulse; sts_err=0; sts_count=4.
- Broadcast write len=2, cmd_bcast=1 → mem_all=1 during both writes; read with cmd_bcast=1 → mem_all=0.
- Read len=8, RD_LATENCY=2, m_tready toggling 1/0 → 8 beats in address order, no loss or duplication, m_tlast on 8th only, at most FIFO_DEPTH reads outstanding.
- Write len=4, TLAST on beat 2 → 2 writes, sts_err=1, sts_count=2, done pulse; next command accept clears sts_err.
- cmd_len=0 → done 2 cycles after accept; no mem_we/mem_re; sts_count=0.
- areset asserted mid-read with FIFO non-empty → all outputs 0 that cycle; next command executes cleanly.
